// File: rtl/data_mem_arbiter_pkg.sv
// Shared FSM encoding and address legality rule for the data memory arbiter.
// Fallback width when defines.v has not been preloaded ahead of this file.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

package data_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   // Word-aligned and inside the attached memory, otherwise rejected.
   function automatic logic addr_err(input logic [`CPU_WIDTH-1:0] addr,
                                     input int unsigned depth);
      return (addr[1:0] != 2'b00) || (addr >= `CPU_WIDTH'(4 * depth));
   endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational winner, pointer updated on upd.
// No backpressure; winner is valid whenever either request is high.
module rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   input  logic upd,
   input  logic upd_idx,
   output logic win
);

   logic last_q;
   logic last_eff;

   // The pointer update and the next arbitration happen in the same cycle,
   // so the port being retired already counts as most recently granted.
   assign last_eff = upd ? upd_idx : last_q;

   always_comb begin
      win = 1'b0;
      if (req1 && (!req0 || !last_eff)) begin
         win = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b1;
      end else if (upd) begin
         last_q <= upd_idx;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-cycle data memory: gnt at +1, rvalid at +2.
// One access in flight; requesters hold their request until granted.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int DEPTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  p0_req,
   input  logic                  p0_wen,
   input  logic [`CPU_WIDTH-1:0] p0_addr,
   input  logic [`CPU_WIDTH-1:0] p0_wdata,
   input  logic                  p1_req,
   input  logic                  p1_wen,
   input  logic [`CPU_WIDTH-1:0] p1_addr,
   input  logic [`CPU_WIDTH-1:0] p1_wdata,
   output logic                  p0_gnt,
   output logic                  p1_gnt,
   output logic                  p0_rvalid,
   output logic                  p1_rvalid,
   output logic                  p0_err,
   output logic                  p1_err,
   output logic [`CPU_WIDTH-1:0] rdata_o,
   output logic                  mem_sel_o,
   output logic                  mem_wen_o,
   output logic [`CPU_WIDTH-1:0] mem_addr_o,
   output logic [`CPU_WIDTH-1:0] mem_wdata_o,
   input  logic [`CPU_WIDTH-1:0] mem_rdata_i
);

   state_t                  state;
   logic                    lat_port;
   logic                    lat_wen;
   logic                    lat_err;
   logic [`CPU_WIDTH-1:0]   lat_addr;
   logic [`CPU_WIDTH-1:0]   lat_wdata;

   logic                    win;
   logic                    issue_st;
   logic                    resp_st;
   logic                    any_req;
   logic                    sel_wen;
   logic [`CPU_WIDTH-1:0]   sel_addr;
   logic [`CPU_WIDTH-1:0]   sel_wdata;

   assign issue_st  = (state == ISSUE);
   assign resp_st   = (state == RESP);
   assign any_req   = p0_req | p1_req;
   assign sel_wen   = win ? p1_wen   : p0_wen;
   assign sel_addr  = win ? p1_addr  : p0_addr;
   assign sel_wdata = win ? p1_wdata : p0_wdata;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req0    (p0_req),
      .req1    (p1_req),
      .upd     (resp_st),
      .upd_idx (lat_port),
      .win     (win)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         lat_port  <= 1'b0;
         lat_wen   <= 1'b0;
         lat_err   <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else begin
         case (state)
            IDLE, RESP: begin
               if (any_req) begin
                  state     <= ISSUE;
                  lat_port  <= win;
                  lat_wen   <= sel_wen;
                  lat_err   <= addr_err(sel_addr, DEPTH);
                  lat_addr  <= sel_addr;
                  lat_wdata <= sel_wdata;
               end else begin
                  state <= IDLE;
               end
            end
            ISSUE:   state <= RESP;
            default: state <= IDLE;
         endcase
      end
   end

   assign p0_gnt    = issue_st & ~lat_port;
   assign p1_gnt    = issue_st &  lat_port;
   assign p0_rvalid = resp_st  & ~lat_port;
   assign p1_rvalid = resp_st  &  lat_port;
   assign p0_err    = p0_rvalid & lat_err;
   assign p1_err    = p1_rvalid & lat_err;

   // rst is folded in so a write landing on the reset edge never reaches memory.
   assign mem_sel_o   = issue_st & ~lat_err & ~rst;
   assign mem_wen_o   = mem_sel_o & lat_wen;
   assign mem_addr_o  = issue_st ? lat_addr  : '0;
   assign mem_wdata_o = issue_st ? lat_wdata : '0;
   assign rdata_o     = (resp_st && !lat_wen && !lat_err) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural single-cycle memory.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module tb_data_mem_arbiter;

   localparam int W     = `CPU_WIDTH;
   localparam int DEPTH = 32;
   localparam int AW    = $clog2(DEPTH);

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         p0_req = 1'b0, p0_wen = 1'b0;
   logic [W-1:0] p0_addr = '0, p0_wdata = '0;
   logic         p1_req = 1'b0, p1_wen = 1'b0;
   logic [W-1:0] p1_addr = '0, p1_wdata = '0;
   logic         p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
   logic [W-1:0] rdata_o;
   logic         mem_sel_o, mem_wen_o;
   logic [W-1:0] mem_addr_o, mem_wdata_o;
   logic [W-1:0] mem_rdata_i = '0;

   logic [W-1:0] mem [DEPTH];
   logic         mem_init = 1'b1;
   int           sel_cnt = 0;
   int           checks = 0;
   int           errors = 0;
   int           cnt0;
   logic [7:0]   ctl;

   assign ctl = {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_sel_o, mem_wen_o};

   always #5 clk = ~clk;

   function automatic logic [W-1:0] init_val(input int i);
      return (i == 1) ? W'(32'hf00f0ff0) : W'(32'h1000_0000 + i);
   endfunction

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
      end else if (mem_sel_o) begin
         sel_cnt <= sel_cnt + 1;
         if (mem_wen_o) mem[mem_addr_o[AW+1:2]] <= mem_wdata_o;
         else           mem_rdata_i <= mem[mem_addr_o[AW+1:2]];
      end
   end

   data_mem_arbiter #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_wen(p0_wen), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p1_req(p1_req), .p1_wen(p1_wen), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
      .p0_err(p0_err), .p1_err(p1_err), .rdata_o(rdata_o),
      .mem_sel_o(mem_sel_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      // ctl bits: p0_gnt p1_gnt p0_rvalid p1_rvalid p0_err p1_err sel wen
      step(); step();
      mem_init = 1'b0;
      chk("reset_ctl",   W'(ctl), W'(8'h00));
      chk("reset_rdata", rdata_o, '0);
      chk("reset_addr",  mem_addr_o, '0);
      rst = 1'b0;
      step();

      // Lone p0 read of word 1
      p0_req = 1'b1; p0_wen = 1'b0; p0_addr = W'(32'h4);
      step();
      chk("t1_gnt",  W'(ctl), W'(8'h82));
      chk("t1_addr", mem_addr_o, W'(32'h4));
      p0_req = 1'b0;
      step();
      chk("t1_resp",  W'(ctl), W'(8'h20));
      chk("t1_rdata", rdata_o, W'(32'hf00f0ff0));
      step();
      chk("t1_idle", W'(ctl), W'(8'h00));

      // p1 write to 0x8, then p0 read requested during p1's RESP cycle
      p1_req = 1'b1; p1_wen = 1'b1; p1_addr = W'(32'h8); p1_wdata = W'(32'h12345678);
      step();
      chk("t2_gnt",   W'(ctl), W'(8'h43));
      chk("t2_wdata", mem_wdata_o, W'(32'h12345678));
      p1_req = 1'b0; p1_wen = 1'b0;
      step();
      chk("t2_resp",  W'(ctl), W'(8'h10));
      chk("t2_rdata", rdata_o, '0);
      p0_req = 1'b1; p0_wen = 1'b0; p0_addr = W'(32'h8);
      step();
      chk("t36_no_idle", W'(ctl), W'(8'h82));
      p0_req = 1'b0;
      step();
      chk("t2_rd_resp",  W'(ctl), W'(8'h20));
      chk("t2_rd_rdata", rdata_o, W'(32'h12345678));
      step();
      chk("t2_idle", W'(ctl), W'(8'h00));

      // Fresh reset, then both ports held: grants alternate starting with p0
      rst = 1'b1;
      step();
      chk("t3_rst", W'(ctl), W'(8'h00));
      rst = 1'b0;
      p0_req = 1'b1; p0_wen = 1'b0; p0_addr = W'(32'h0);
      p1_req = 1'b1; p1_wen = 1'b0; p1_addr = W'(32'h4);
      for (int k = 0; k < 8; k++) begin
         step();
         if (k % 2 == 0) begin
            chk($sformatf("t3_gnt_c%0d", k + 1), W'(ctl), (k % 4 == 0) ? W'(8'h82) : W'(8'h42));
            if (k == 6) begin
               p0_req = 1'b0; p1_req = 1'b0;
            end
         end else begin
            chk($sformatf("t3_rv_c%0d", k + 1), W'(ctl), (k % 4 == 1) ? W'(8'h20) : W'(8'h10));
            chk($sformatf("t3_rd_c%0d", k + 1), rdata_o,
                (k % 4 == 1) ? W'(32'h1000_0000) : W'(32'hf00f0ff0));
         end
      end
      step();
      chk("t3_idle", W'(ctl), W'(8'h00));

      // Misaligned p0 read and out-of-range p1 write; p1 was granted last
      cnt0 = sel_cnt;
      p0_req = 1'b1; p0_wen = 1'b0; p0_addr = W'(32'h6);
      p1_req = 1'b1; p1_wen = 1'b1; p1_addr = W'(32'h80); p1_wdata = W'(32'hdeadbeef);
      step();
      chk("t4_p0_gnt", W'(ctl), W'(8'h80));
      p0_req = 1'b0;
      step();
      chk("t4_p0_err",   W'(ctl), W'(8'h28));
      chk("t4_p0_rdata", rdata_o, '0);
      step();
      chk("t4_p1_gnt", W'(ctl), W'(8'h40));
      p1_req = 1'b0; p1_wen = 1'b0;
      step();
      chk("t4_p1_err",   W'(ctl), W'(8'h14));
      chk("t4_p1_rdata", rdata_o, '0);
      step();
      chk("t4_no_sel", W'(sel_cnt), W'(cnt0));
      chk("t4_mem0",   mem[0], W'(32'h1000_0000));

      // Reset lands on the ISSUE cycle of a p1 write
      p1_req = 1'b1; p1_wen = 1'b1; p1_addr = W'(32'hC); p1_wdata = W'(32'haaaa5555);
      step();
      rst = 1'b1;
      #1;
      chk("t5_sel_gated", W'(mem_sel_o), '0);
      p1_req = 1'b0; p1_wen = 1'b0;
      step();
      rst = 1'b0;
      chk("t5_after_rst", W'(ctl), W'(8'h00));
      chk("t5_rdata",     rdata_o, '0);
      step();
      chk("t5_no_rvalid", W'(ctl), W'(8'h00));
      chk("t5_mem3",      mem[3], W'(32'h1000_0003));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
